// File: rtl/rl_ram_nr1w.sv
// Multi-read-port RAM with one byte-masked write port and write-first bypass.
// Synchronous read-old array; bypass lanes are merged after the array register.
module rl_ram_nr1w #(
    parameter int ABITS  = 10,
    parameter int DBITS  = 32,
    parameter int NRP    = 2,
    parameter int OUTREG = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [ABITS-1:0]         waddr_i,
    input  logic [DBITS-1:0]         din_i,
    input  logic                     we_i,
    input  logic [(DBITS+7)/8-1:0]   be_i,
    input  logic [NRP*ABITS-1:0]     raddr_i,
    input  logic [NRP-1:0]           re_i,
    output logic [NRP*DBITS-1:0]     dout_o,
    output logic [NRP-1:0]           dvalid_o
);

    localparam int NB    = (DBITS + 7) / 8;
    localparam int DEPTH = 1 << ABITS;

    logic [DBITS-1:0] mem_array [DEPTH];
    logic [DBITS-1:0] we_bits;
    logic             wr_en;

    logic [NRP-1:0][ABITS-1:0] rd_addr;

    logic [NRP-1:0][DBITS-1:0] rdata_d, rdata_q;
    logic [NRP-1:0][DBITS-1:0] wdata_d, wdata_q;
    logic [NRP-1:0][NB-1:0]    lane_d, lane_q;
    logic [NRP-1:0][DBITS-1:0] merged;

    assign rd_addr = raddr_i;
    assign wr_en   = we_i & ~rst_i;

    for (genvar i = 0; i < DBITS; i++) begin : g_we_bits
        assign we_bits[i] = be_i[i/8];
    end

    // Storage is deliberately left out of reset so contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_array[waddr_i] <= (mem_array[waddr_i] & ~we_bits) | (din_i & we_bits);
        end
    end

    // Per-port capture so a port that is not reading keeps its merged result stable.
    always_comb begin
        rdata_d = rdata_q;
        wdata_d = wdata_q;
        lane_d  = lane_q;
        for (int p = 0; p < NRP; p++) begin
            if (re_i[p]) begin
                rdata_d[p] = mem_array[rd_addr[p]];
                wdata_d[p] = din_i;
                lane_d[p]  = (we_i && (waddr_i == rd_addr[p])) ? be_i : '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
            wdata_q <= '0;
            lane_q  <= '0;
        end else begin
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
            lane_q  <= lane_d;
        end
    end

    for (genvar p = 0; p < NRP; p++) begin : g_merge_port
        for (genvar i = 0; i < DBITS; i++) begin : g_merge_bit
            assign merged[p][i] = lane_q[p][i/8] ? wdata_q[p][i] : rdata_q[p][i];
        end
    end

    if (OUTREG == 0) begin : g_out_direct
        logic [NRP-1:0] vld_d, vld_q;

        always_comb begin
            vld_d = vld_q | re_i;
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                vld_q <= '0;
            end else begin
                vld_q <= vld_d;
            end
        end

        assign dout_o   = merged;
        assign dvalid_o = vld_q;
    end else begin : g_out_reg
        logic [NRP-1:0]            s1_fire_d, s1_fire_q;
        logic [NRP-1:0]            vld_d, vld_q;
        logic [NRP-1:0][DBITS-1:0] dout_d, dout_q;

        always_comb begin
            s1_fire_d = re_i;
            vld_d     = vld_q | s1_fire_q;
            dout_d    = dout_q;
            for (int p = 0; p < NRP; p++) begin
                if (s1_fire_q[p]) begin
                    dout_d[p] = merged[p];
                end
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                s1_fire_q <= '0;
                vld_q     <= '0;
                dout_q    <= '0;
            end else begin
                s1_fire_q <= s1_fire_d;
                vld_q     <= vld_d;
                dout_q    <= dout_d;
            end
        end

        assign dout_o   = dout_q;
        assign dvalid_o = vld_q;
    end

endmodule

// File: tb/tb_rl_ram_nr1w.sv
// Bench for rl_ram_nr1w: one OUTREG=0 and one OUTREG=1 instance share stimulus
// and are checked every cycle against a write-first word-level model.
module tb_rl_ram_nr1w;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  waddr = '0;
    logic [31:0] din = '0;
    logic        we = 1'b0;
    logic [3:0]  be = '0;
    logic [19:0] raddr = '0;
    logic [1:0]  re = '0;

    logic [63:0] dout0, dout1;
    logic [1:0]  dval0, dval1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rl_ram_nr1w #(.ABITS(10), .DBITS(32), .NRP(2), .OUTREG(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .waddr_i(waddr), .din_i(din), .we_i(we),
        .be_i(be), .raddr_i(raddr), .re_i(re), .dout_o(dout0), .dvalid_o(dval0)
    );

    rl_ram_nr1w #(.ABITS(10), .DBITS(32), .NRP(2), .OUTREG(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .waddr_i(waddr), .din_i(din), .we_i(we),
        .be_i(be), .raddr_i(raddr), .re_i(re), .dout_o(dout1), .dvalid_o(dval1)
    );

    // Model: word array with a known-bit mask; reads see the write of the same edge.
    logic [31:0] mem_m [1024];
    bit   [31:0] kn_m  [1024];
    logic [31:0] e0_d [2], e1_d [2], pd [2];
    bit   [31:0] e0_k [2], e1_k [2], pk [2];
    bit          e0_v [2], e1_v [2], pv [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                e0_d[p] = '0; e1_d[p] = '0; pd[p] = '0;
                e0_k[p] = '1; e1_k[p] = '1; pk[p] = '1;
                e0_v[p] = 0;  e1_v[p] = 0;  pv[p] = 0;
            end
        end else begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem_m[waddr][8*b +: 8] = din[8*b +: 8];
                        kn_m[waddr][8*b +: 8]  = 8'hFF;
                    end
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (pv[p]) begin
                    e1_d[p] = pd[p]; e1_k[p] = pk[p]; e1_v[p] = 1;
                end
                pv[p] = re[p];
                if (re[p]) begin
                    e0_d[p] = mem_m[raddr[p*10 +: 10]];
                    e0_k[p] = kn_m[raddr[p*10 +: 10]];
                    e0_v[p] = 1;
                    pd[p] = e0_d[p]; pk[p] = e0_k[p];
                end
            end
        end
    end

    task automatic mcheck(input string nm, input int p, input logic [31:0] act,
                          input logic [31:0] exp, input logic [31:0] mask);
        n_checks++;
        if (((act ^ exp) & mask) != 32'h0) begin
            n_fail++;
            $display("FAIL %s port%0d: got %h expected %h (mask %h) t=%0t", nm, p, act, exp, mask, $time);
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (rst) begin
                mcheck("rst_dvalid0", p, {31'b0, dval0[p]}, 32'h0, '1);
                mcheck("rst_dvalid1", p, {31'b0, dval1[p]}, 32'h0, '1);
                mcheck("rst_dout0", p, dout0[p*32 +: 32], 32'h0, '1);
                mcheck("rst_dout1", p, dout1[p*32 +: 32], 32'h0, '1);
            end else begin
                mcheck("dvalid0", p, {31'b0, dval0[p]}, {31'b0, e0_v[p]}, '1);
                mcheck("dvalid1", p, {31'b0, dval1[p]}, {31'b0, e1_v[p]}, '1);
                if (e0_v[p]) mcheck("dout0", p, dout0[p*32 +: 32], e0_d[p], e0_k[p]);
                if (e1_v[p]) mcheck("dout1", p, dout1[p*32 +: 32], e1_d[p], e1_k[p]);
            end
        end
    end

    task automatic cyc(input logic w, input logic [9:0] wa, input logic [31:0] d,
                       input logic [3:0] b, input logic [1:0] r,
                       input logic [9:0] a0, input logic [9:0] a1);
        we = w; waddr = wa; din = d; be = b; re = r; raddr = {a1, a0};
        @(posedge clk);
        #1;
        we = 1'b0; re = 2'b00;
    endtask

    logic [9:0] addrs [8];

    initial begin
        addrs[0] = 10'd0;  addrs[1] = 10'd3;  addrs[2] = 10'd4;  addrs[3] = 10'd5;
        addrs[4] = 10'd7;  addrs[5] = 10'd9;  addrs[6] = 10'd10; addrs[7] = 10'd1023;

        cyc(0, 0, 0, 0, 2'b00, 0, 0);
        cyc(0, 0, 0, 0, 2'b00, 0, 0);
        check("reset_dvalid0", {30'b0, dval0}, 32'h0);
        check("reset_dout1", dout1[31:0], 32'h0);
        rst = 1'b0;

        cyc(1, 10'd5,    32'h0,        4'hF, 2'b00, 0, 0);
        cyc(1, 10'd7,    32'hAABBCCDD, 4'hF, 2'b00, 0, 0);
        cyc(1, 10'd10,   32'h0A0A0A0A, 4'hF, 2'b00, 0, 0);
        cyc(1, 10'd9,    32'h99999999, 4'hF, 2'b00, 0, 0);
        cyc(1, 10'd4,    32'h00000001, 4'hF, 2'b00, 0, 0);
        cyc(1, 10'd3,    32'h0,        4'hF, 2'b00, 0, 0);
        cyc(1, 10'd0,    32'h0,        4'hF, 2'b00, 0, 0);
        cyc(1, 10'd1023, 32'h0,        4'hF, 2'b00, 0, 0);

        // Writes during reset must be dropped.
        rst = 1'b1;
        cyc(1, 10'd5, 32'hDEADBEEF, 4'hF, 2'b11, 10'd5, 10'd5);
        check("rst_write_dvalid", {30'b0, dval0}, 32'h0);
        rst = 1'b0;
        cyc(0, 0, 0, 0, 2'b11, 10'd5, 10'd5);
        check("addr5_after_rst", dout0[31:0], 32'h0);
        check("addr5_dvalid", {30'b0, dval0}, 32'h3);

        cyc(1, 10'd3, 32'h12345678, 4'hF, 2'b00, 0, 0);
        cyc(0, 0, 0, 0, 2'b11, 10'd3, 10'd3);
        check("basic_p0", dout0[31:0], 32'h12345678);
        check("basic_p1", dout0[63:32], 32'h12345678);
        cyc(0, 0, 0, 0, 2'b00, 0, 0);
        check("basic_or1_p1", dout1[63:32], 32'h12345678);
        check("basic_or1_dvalid", {30'b0, dval1}, 32'h3);

        cyc(1, 10'd7, 32'h11223344, 4'h5, 2'b01, 10'd7, 0);
        check("bypass_merge", dout0[31:0], 32'hAA22CC44);
        cyc(0, 0, 0, 0, 2'b01, 10'd7, 0);
        check("merge_reread", dout0[31:0], 32'hAA22CC44);

        cyc(1, 10'd9, 32'hCAFEF00D, 4'hF, 2'b11, 10'd9, 10'd10);
        check("indep_p0", dout0[31:0], 32'hCAFEF00D);
        check("indep_p1", dout0[63:32], 32'h0A0A0A0A);

        cyc(0, 0, 0, 0, 2'b01, 10'd4, 0);
        cyc(1, 10'd4, 32'h2, 4'hF, 2'b10, 0, 10'd4);
        check("or1_order_p0", dout1[31:0], 32'h1);
        cyc(0, 0, 0, 0, 2'b00, 0, 0);
        check("or1_new_p1", dout1[63:32], 32'h2);

        cyc(1, 10'd0, 32'h00C0FFEE, 4'hF, 2'b00, 0, 0);
        cyc(1, 10'd1023, 32'hFFFF0001, 4'hF, 2'b11, 10'd0, 10'd1023);
        check("addr0", dout0[31:0], 32'h00C0FFEE);
        check("addr_max", dout0[63:32], 32'hFFFF0001);
        for (int i = 0; i < 3; i++) cyc(1, 10'd0, 32'h12121212, 4'hF, 2'b00, 0, 0);
        check("hold_or0", dout0[31:0], 32'h00C0FFEE);
        check("hold_or1", dout1[31:0], 32'h00C0FFEE);

        // Reset lands while the OUTREG=1 result is still in flight.
        cyc(0, 0, 0, 0, 2'b01, 10'd3, 0);
        rst = 1'b1;
        #1;
        check("midrd_dout1", dout1[31:0], 32'h0);
        check("midrd_dvalid1", {30'b0, dval1}, 32'h0);
        cyc(0, 0, 0, 0, 2'b00, 0, 0);
        rst = 1'b0;
        cyc(0, 0, 0, 0, 2'b01, 10'd9, 0);
        check("post_rst_p0", dout0[31:0], 32'hCAFEF00D);
        check("post_rst_dvalid0", {30'b0, dval0}, 32'h1);
        cyc(0, 0, 0, 0, 2'b00, 0, 0);
        check("post_rst_or1", dout1[31:0], 32'hCAFEF00D);

        for (int i = 0; i < 40; i++) begin
            cyc(1'($urandom_range(0, 1)), addrs[$urandom_range(0, 7)], $urandom,
                4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                addrs[$urandom_range(0, 7)], addrs[$urandom_range(0, 7)]);
        end
        cyc(0, 0, 0, 0, 2'b00, 0, 0);
        cyc(0, 0, 0, 0, 2'b00, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rl_ram_nr1w.md
# rl_ram_nr1w

Parametrised multi-read-port RAM: one write port, NRP independent read ports, per-byte write enables, and full write-to-read bypass with byte-lane merging. An optional output register stage gives a 2-cycle read latency. Read ports carry a valid flag. It serves as the storage primitive for register files, BTB/BHT tables and cache tag/data arrays that need several lookups per cycle and correct read-during-write data.

## Interface
Parameters:
- ABITS, 10, address width; depth = 2**ABITS words.
- DBITS, 32, data width; byte lanes NB = (DBITS+7)/8; last lane covers DBITS-8*(NB-1) bits.
- NRP, 2, number of read ports, 1..4.
- OUTREG, 0, 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- waddr_i  in  ABITS  write address.
- din_i  in  DBITS  write data.
- we_i  in  1  write strobe.
- be_i  in  NB  byte enables; lane b covers din_i[8b+7:8b].
- raddr_i  in  NRP*ABITS  read addresses; port p at [p*ABITS +: ABITS].
- re_i  in  NRP  read strobes, one per port.
- dout_o  out  NRP*DBITS  read data; port p at [p*DBITS +: DBITS].
- dvalid_o  out  NRP  dout_o for port p holds data from a completed read.

## Operation
- Write: on a clock edge with we_i=1 and rst_i=0, each lane b with be_i[b]=1 is written. Lanes with be_i[b]=0 keep their contents. we_i=1 with be_i=0 is a no-op.
- Storage array is not reset. Contents are undefined until written and are retained across rst_i.
- While rst_i=1, we_i and re_i are ignored: no writes, no reads.
- Read: re_i[p]=1 at edge T samples raddr_i[p]. Result = array contents after the write of edge T is applied (write-first).
- Bypass: if we_i=1 and waddr_i==raddr_i[p] at edge T, lanes with be_i[b]=1 come from din_i and other lanes from the old array word. No X from the array may reach dout_o on enabled lanes.
- Each port bypasses independently. Several ports reading the same address each get the merged result.
- re_i[p]=0: dout_o[p] and dvalid_o[p] hold their previous values. No array read is required.
- OUTREG=1: the stage-1 result (merged data, valid) is registered. A write at T+1 does not alter data for a read sampled at T.
- Implementation: array read is synchronous with read-old semantics. Register din_i, be_i and a per-port hit flag at T, then merge combinationally after the array output (OUTREG=0) or before the output register (OUTREG=1).

## Timing
- Reset values: dout_o = 0, dvalid_o = 0. All bypass and pipeline registers are cleared asynchronously.
- Latency, OUTREG=0: re at edge T gives dout_o/dvalid_o valid after edge T+1... strictly, valid in the cycle following edge T, updated by edge T itself.
- Latency, OUTREG=1: valid after edge T+1.
- dvalid_o[p] is sticky: set by the first completed read, cleared only by reset.
- Back-to-back reads on every cycle are supported on all ports (throughput 1 per port per cycle).
- Reset asserted mid-read: the in-flight result is discarded and outputs go to 0 immediately. After deassertion, the first read behaves normally.
- Address wrap: none; full 2**ABITS range is valid. Addresses 0 and 2**ABITS-1 must be verified.

## Test plan
- Reset and read: assert rst_i, write addr 5 = 0xDEADBEEF during reset, then release and read addr 5 → no write occurred (pre-load 0x0 first); dout_o=0 and dvalid_o=0 during reset.
- Basic write then read: DBITS=32, write addr 3 = 0x12345678 with be=0xF, next cycle read ports 0 and 1 at addr 3 → both return 0x12345678 at the stated latency; dvalid_o=2'b11.
- Byte-merge bypass: addr 7 holds 0xAABBCCDD. In the same cycle write 0x11223344 with be=0x5 and read addr 7 on port 0 → 0xAA22CC44. Next-cycle read of addr 7 → 0xAA22CC44.
- Independent ports: same cycle, write addr 9, port 0 reads addr 9, port 1 reads addr 10 → port 0 gets the bypassed data, port 1 gets the old addr 10 data.
- OUTREG=1 ordering: read addr 4 (holds 0x1) at T, write addr 4 = 0x2 at T+1 → output after T+1 is 0x1. A read at T+1 returns 0x2.
- Hold and edge addresses: write and read addresses 0 and 2**ABITS-1 → correct data. Then drop re_i for 3 cycles while the write changes addr 0 → dout_o unchanged.
